apb_master_bridge: RTL
======================

// Module: apb_master_bridge
// PURPOSE
//  Upstream stage of the APB memory slave: converts a valid/ready command stream into
//  APB3 transfers (SETUP->ACCESS), waits on pready, returns read data/error on a
//  valid/ready response channel. One outstanding transfer; per-access timeout guard.
// PARAMETERS
//  ADDR_WIDTH      8    width of cmd_addr/paddr
//  DATA_WIDTH      32   width of write/read data
//  TIMEOUT_CYCLES  16   max ACCESS cycles without pready before abort (>=2)
// PORTS
//  pclk         in   1           clock, all logic on rising edge
//  prst         in   1           reset, asynchronous, active-low
//  cmd_valid    in   1           command present
//  cmd_ready    out  1           bridge accepts command this cycle
//  cmd_write    in   1           1=write, 0=read
//  cmd_addr     in   ADDR_WIDTH  target address
//  cmd_wdata    in   DATA_WIDTH  write data (ignored on read)
//  rsp_valid    out  1           response present
//  rsp_ready    in   1           consumer takes response
//  rsp_rdata    out  DATA_WIDTH  read data (0 for writes/timeouts)
//  rsp_slverr   out  1           pslverr sampled, or timeout
//  rsp_timeout  out  1           transfer aborted by timeout
//  psel         out  1           APB select
//  penable      out  1           APB enable
//  pwrite       out  1           APB direction
//  paddr        out  ADDR_WIDTH  APB address
//  pw_data      out  DATA_WIDTH  APB write data
//  pr_data      in   DATA_WIDTH  APB read data
//  pready       in   1           APB ready
//  pslverr      in   1           APB error
// BEHAVIOUR
//  Reset (prst=0, async): state=IDLE; every output 0 except cmd_ready=1 once out of reset
//   (cmd_ready is combinational from state; 0 while prst=0); timeout count=0.
//  FSM IDLE->SETUP->ACCESS->RESP->IDLE; ACCESS->RESP also on timeout.
//  IDLE: cmd_ready=1. cmd_valid&&cmd_ready at edge: register write/addr/wdata, go SETUP.
//  SETUP (exactly 1 cycle): psel=1, penable=0, pwrite/paddr/pw_data driven from regs.
//  ACCESS: psel=1, penable=1, addr/data/pwrite stable. Count cycles from 1.
//   pready=1 at edge: capture pr_data (reads only, else 0) and pslverr into rsp regs, go RESP.
//   count==TIMEOUT_CYCLES and pready=0: go RESP with rsp_slverr=1, rsp_timeout=1, rdata=0.
//  RESP: psel=penable=0, rsp_valid=1, rsp_* held stable until rsp_valid&&rsp_ready; then IDLE.
//  Latency: cmd accept -> psel=1 next cycle; min cmd accept -> rsp_valid = 3 cycles
//   (pready high on first ACCESS cycle). Back-to-back: next cmd accepted earliest the
//   cycle after response handshake (no overlap; cmd_ready=0 outside IDLE).
//  pready/pslverr/pr_data ignored outside ACCESS. psel never drops mid-transfer except on
//   timeout or reset. paddr/pw_data/pwrite hold last values in IDLE/RESP (no glitch to 0).
//  Reset mid-transfer: psel/penable drop asynchronously, pending response discarded.
//  Timeout counter saturates; width $clog2(TIMEOUT_CYCLES+1).
// STRUCTURE
//  apb_pkg: typedef enum logic [1:0] {IDLE,SETUP,ACCESS,RESP} apb_mst_state_t;
//   ADDR_WIDTH/DATA_WIDTH defaults shared with the slave memory.
//  Sub-module apb_timeout_cnt (pclk, prst, clr, en -> expired) holds the ACCESS counter.
//  Top: FSM, command capture regs, response regs, output decode.
// TESTING (bench pairs the bridge with the APB memory slave, MEM_SIZE=16)
//  Write 0x05<-0xDEADBEEF, read 0x05 -> rsp_rdata=0xDEADBEEF, slverr=0, timeout=0.
//  Read 0x20 (>=MEM_SIZE) -> rsp_slverr=1, rsp_timeout=0, rsp_rdata=0.
//  Stub slave pready=0 forever -> rsp_valid after SETUP+16 ACCESS cycles, slverr=1, timeout=1.
//  rsp_ready held 0 for 5 cycles -> rsp_* stable, cmd_ready=0, psel=0 throughout.
//  cmd_valid held high with 4 writes -> exactly one APB transfer per handshake, SETUP
//   always 1 cycle with penable=0, no back-to-back psel without IDLE gap.
//  prst low during ACCESS -> psel/penable/rsp_valid 0 immediately; next cmd runs normally.

Source files
------------

// File: rtl/apb_pkg.sv
// apb_pkg: shared APB widths and the master bridge state type.
package apb_pkg;
    localparam int APB_ADDR_WIDTH = 8;
    localparam int APB_DATA_WIDTH = 32;
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} apb_mst_state_t;
endpackage

// File: rtl/apb_timeout_cnt.sv
// apb_timeout_cnt: saturating cycle counter that flags when an APB access has waited too long.
module apb_timeout_cnt #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic pclk,
    input  logic prst,
    input  logic clr,
    input  logic en,
    output logic expired
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] MAX = CW'(TIMEOUT_CYCLES);

    logic [CW-1:0] cnt;

    always_ff @(posedge pclk or negedge prst)
        if (!prst)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (en && cnt != MAX)
            cnt <= cnt + 1'b1;

    assign expired = cnt == MAX;
endmodule

// File: rtl/apb_master_bridge.sv
// apb_master_bridge: turns a valid/ready command stream into single APB3 transfers
// and returns the result on a valid/ready response channel, aborting stuck accesses.
module apb_master_bridge
    import apb_pkg::*;
#(
    parameter int ADDR_WIDTH     = APB_ADDR_WIDTH,
    parameter int DATA_WIDTH     = APB_DATA_WIDTH,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  pclk,
    input  logic                  prst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_slverr,
    output logic                  rsp_timeout,
    output logic                  psel,
    output logic                  penable,
    output logic                  pwrite,
    output logic [ADDR_WIDTH-1:0] paddr,
    output logic [DATA_WIDTH-1:0] pw_data,
    input  logic [DATA_WIDTH-1:0] pr_data,
    input  logic                  pready,
    input  logic                  pslverr
);
    apb_mst_state_t state, state_nxt;

    logic                  wr_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  slverr_q;
    logic                  timeout_q;
    logic                  expired;
    logic                  cnt_en;
    logic                  cmd_fire;
    logic                  acc_done;

    // cmd_ready must stay low while reset is held even though state already reads IDLE
    assign cmd_ready = prst && state == IDLE;
    assign cmd_fire  = cmd_valid && cmd_ready;
    assign acc_done  = state == ACCESS && (pready || expired);
    assign cnt_en    = state == SETUP || state == ACCESS;

    apb_timeout_cnt #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout_cnt (
        .pclk    (pclk),
        .prst    (prst),
        .clr     (!cnt_en),
        .en      (cnt_en),
        .expired (expired)
    );

    always_ff @(posedge pclk or negedge prst)
        if (!prst) begin
            state     <= IDLE;
            wr_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            slverr_q  <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state <= state_nxt;
            if (cmd_fire) begin
                wr_q    <= cmd_write;
                addr_q  <= cmd_addr;
                wdata_q <= cmd_wdata;
            end
            // a completing slave wins over a timeout landing on the same edge
            if (acc_done) begin
                rdata_q   <= (pready && !wr_q) ? pr_data : '0;
                slverr_q  <= pready ? pslverr : 1'b1;
                timeout_q <= !pready;
            end
        end

    always_comb begin
        state_nxt = state;
        psel      = 1'b0;
        penable   = 1'b0;
        rsp_valid = 1'b0;
        case (state)
            IDLE:    state_nxt = cmd_fire ? SETUP : IDLE;
            SETUP: begin
                psel      = 1'b1;
                state_nxt = ACCESS;
            end
            ACCESS: begin
                psel      = 1'b1;
                penable   = 1'b1;
                state_nxt = acc_done ? RESP : ACCESS;
            end
            RESP: begin
                rsp_valid = 1'b1;
                state_nxt = rsp_ready ? IDLE : RESP;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign pwrite      = wr_q;
    assign paddr       = addr_q;
    assign pw_data     = wdata_q;
    assign rsp_rdata   = rdata_q;
    assign rsp_slverr  = slverr_q;
    assign rsp_timeout = timeout_q;
endmodule
